// File: rtl/wisard_classify_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wisard_classify_ctrl
// Purpose  : Sequences one WiSARD sample through the N_RAMS tuple lookups of
//            every discriminator, accumulates per-class hit counts, scans the
//            scores for the maximum and hands the winning class downstream.
// Ports    : clk, rst_n (synchronous, active-low)
//            s_valid/s_sop/s_ready   - upstream tuple beat stream
//            ram_rd_en/ram_index     - RAM lookup strobe and RAM select
//            hit_vec                 - per-class hit, one cycle after lookup
//            out_valid/out_ready     - result handshake
//            out_class/out_score     - winning class id and its score
//            out_tie (optional)      - winner was tied by a higher class id
// Options  : WISARD_TIE_FLAG_EN adds the out_tie output.
// Revision : 1.0 - initial release
// ============================================================================
module wisard_classify_ctrl #(
  parameter int INDEX_WIDTH = 5,
  parameter int N_RAMS      = 27,
  parameter int N_CLASSES   = 10,
  parameter int CLASS_WIDTH = 4,
  parameter int SCORE_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  input  logic                   s_sop,
  output logic                   s_ready,
  output logic                   ram_rd_en,
  output logic [INDEX_WIDTH-1:0] ram_index,
  input  logic [N_CLASSES-1:0]   hit_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLASS_WIDTH-1:0] out_class,
  output logic [SCORE_WIDTH-1:0] out_score
`ifdef WISARD_TIE_FLAG_EN
  ,
  output logic                   out_tie
`endif
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(N_RAMS - 1);
  localparam logic [CLASS_WIDTH-1:0] LAST_CLASS = CLASS_WIDTH'(N_CLASSES - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SCAN  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t                                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]                   index_q, index_d;
  logic [N_CLASSES-1:0][SCORE_WIDTH-1:0]    scores_q, scores_d;
  logic                                     hit_pend_q, hit_pend_d;
  logic                                     clr_pend_q, clr_pend_d;
  logic [CLASS_WIDTH-1:0]                   ptr_q, ptr_d;
  logic [SCORE_WIDTH-1:0]                   best_score_q, best_score_d;
  logic [CLASS_WIDTH-1:0]                   best_class_q, best_class_d;
  logic                                     out_valid_q, out_valid_d;
  logic [CLASS_WIDTH-1:0]                   out_class_q, out_class_d;
  logic [SCORE_WIDTH-1:0]                   out_score_q, out_score_d;
`ifdef WISARD_TIE_FLAG_EN
  logic                                     tie_q, tie_d;
  logic                                     out_tie_q, out_tie_d;
`endif

  // Captured score for each class: the pending hit added to either the held
  // score or zero (first beat of a frame), saturating at the top code.
  logic [N_CLASSES-1:0][SCORE_WIDTH-1:0]    w_capt;

  generate
    for (genvar c = 0; c < N_CLASSES; c++) begin : g_score
      logic [SCORE_WIDTH-1:0] w_base;
      assign w_base    = clr_pend_q ? '0 : scores_q[c];
      assign w_capt[c] = (w_base == SCORE_MAX) ? w_base
                                               : w_base + SCORE_WIDTH'(hit_vec[c]);
    end
  endgenerate

  // A start-of-packet beat always maps to RAM 0, restarting the frame.
  assign s_ready   = (state_q == ST_ACCUM);
  assign ram_rd_en = s_valid & s_ready;
  assign ram_index = s_sop ? '0 : index_q;

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
`ifdef WISARD_TIE_FLAG_EN
  assign out_tie   = out_tie_q;
`endif

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    scores_d     = scores_q;
    hit_pend_d   = 1'b0;
    clr_pend_d   = clr_pend_q;
    ptr_d        = ptr_q;
    best_score_d = best_score_q;
    best_class_d = best_class_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
`ifdef WISARD_TIE_FLAG_EN
    tie_d        = tie_q;
    out_tie_d    = out_tie_q;
`endif

    // RAM data arrives the cycle after the lookup, independent of state;
    // this is what lets DRAIN pick up the final beat's hits.
    if (hit_pend_q) begin
      scores_d = w_capt;
    end

    case (state_q)
      ST_ACCUM: begin
        if (ram_rd_en) begin
          hit_pend_d = 1'b1;
          clr_pend_d = s_sop;
          if (ram_index == LAST_IDX) begin
            index_d = '0;
            state_d = ST_DRAIN;
          end else begin
            index_d = ram_index + INDEX_WIDTH'(1);
          end
        end
      end

      ST_DRAIN: begin
        state_d      = ST_SCAN;
        ptr_d        = '0;
        best_score_d = '0;
        best_class_d = '0;
`ifdef WISARD_TIE_FLAG_EN
        tie_d        = 1'b0;
`endif
      end

      ST_SCAN: begin
        // Strict compare: on equal scores the lower class id stays the winner.
        if (scores_q[ptr_q] > best_score_q) begin
          best_score_d = scores_q[ptr_q];
          best_class_d = ptr_q;
`ifdef WISARD_TIE_FLAG_EN
          tie_d        = 1'b0;
        end else if ((scores_q[ptr_q] == best_score_q) && (best_score_q != '0)) begin
          tie_d        = 1'b1;
`endif
        end
        if (ptr_q == LAST_CLASS) begin
          out_valid_d = 1'b1;
          out_class_d = best_class_d;
          out_score_d = best_score_d;
`ifdef WISARD_TIE_FLAG_EN
          out_tie_d   = tie_d;
`endif
          state_d     = ST_OUT;
        end else begin
          ptr_d = ptr_q + CLASS_WIDTH'(1);
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          scores_d    = '0;
          state_d     = ST_ACCUM;
        end
      end

      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      index_q      <= '0;
      scores_q     <= '0;
      hit_pend_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      ptr_q        <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_score_q  <= '0;
`ifdef WISARD_TIE_FLAG_EN
      tie_q        <= 1'b0;
      out_tie_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      scores_q     <= scores_d;
      hit_pend_q   <= hit_pend_d;
      clr_pend_q   <= clr_pend_d;
      ptr_q        <= ptr_d;
      best_score_q <= best_score_d;
      best_class_q <= best_class_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
`ifdef WISARD_TIE_FLAG_EN
      tie_q        <= tie_d;
      out_tie_q    <= out_tie_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/wisard_classify_ctrl.md
Name: wisard_classify_ctrl

Overview:
- Sequences one WiSARD sample through the N_RAMS tuple lookups of every discriminator.
- Accepts one tuple address per beat from the upstream tuple stream and drives the RAM read index plus read enable.
- Accumulates the per-class hit vector returned by the RAMs one cycle later.
- After the last tuple, scans the class scores for the maximum and presents the winning class downstream with a valid/ready handshake.

Parameters:
- INDEX_WIDTH, 5: width of the RAM index.
- N_RAMS, 27: tuples (RAMs) per discriminator; frame length in beats.
- N_CLASSES, 10: number of discriminators.
- CLASS_WIDTH, 4: width of the class id; must satisfy 2^CLASS_WIDTH >= N_CLASSES.
- SCORE_WIDTH, 5: width of one class score; must satisfy 2^SCORE_WIDTH > N_RAMS.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset; synchronous, active-low.
- s_valid, input, 1: upstream tuple beat valid.
- s_sop, input, 1: beat is the first tuple of a sample.
- s_ready, output, 1: controller accepts a tuple beat.
- ram_rd_en, output, 1: RAM lookup strobe. Combinational: s_valid & s_ready.
- ram_index, output, INDEX_WIDTH: RAM select for the current beat. Combinational: 0 if s_sop, else the internal index.
- hit_vec, input, N_CLASSES: per-class RAM hit. Valid exactly one cycle after ram_rd_en.
- out_valid, output, 1: classification result valid.
- out_ready, input, 1: downstream accepts the result.
- out_class, output, CLASS_WIDTH: winning class.
- out_score, output, SCORE_WIDTH: winning score.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=ACCUM, index=0, all scores=0, hit_pend=0, ptr=0.
  - out_valid=0, out_class=0, out_score=0.
  - Reset mid-frame or mid-scan discards all partial results; nothing is output.
- States: ACCUM, DRAIN, SCAN, OUT. s_ready=1 only in ACCUM.
- ACCUM, beat accepted:
  - hit_pend<=1.
  - clr_pend<=s_sop.
  - If ram_index==N_RAMS-1: index<=0 and state<=DRAIN. Otherwise index<=ram_index+1.
  - s_sop on any beat restarts the frame: that beat is index 0 and the scores are cleared before its hit is added.
- Hit capture, every cycle with hit_pend=1:
  - score[c] <= (clr_pend ? 0 : score[c]) + hit_vec[c], for each class c.
  - Scores saturate at 2^SCORE_WIDTH-1.
  - hit_pend<=0 unless a new beat is accepted in the same cycle.
- Accepted beats with s_valid gaps: index holds through the gaps; no lookup is issued.
- DRAIN: lasts one cycle; the last hit is captured. Then state<=SCAN with ptr=0, best_score=0, best_class=0.
- SCAN: one class per cycle.
  - If score[ptr] > best_score (strict): best_score and best_class are updated.
  - A tie keeps the lower class id.
  - After ptr==N_CLASSES-1: out_class<=best_class, out_score<=best_score, out_valid<=1, state<=OUT.
  - An all-zero score set yields class 0, score 0.
- OUT:
  - out_valid held high; out_class and out_score held stable until out_ready.
  - On out_valid & out_ready: out_valid<=0, all scores<=0, state<=ACCUM.
  - The next frame's first beat may be accepted on the following cycle.
- Latency: with the last beat accepted at edge E, out_valid rises after edge E+N_CLASSES+1. For the defaults, out_valid is high 11 cycles after the eop beat.
- Throughput: one frame per N_RAMS+N_CLASSES+2 cycles when there are no stalls.
- No simultaneous upstream and downstream activity: s_ready stays 0 from DRAIN through the OUT handshake.

Optional Feature:
- WISARD_TIE_FLAG_EN defined: adds output out_tie (1 bit, reset 0).
  - In SCAN, set when score[ptr]==best_score and best_score!=0.
  - Cleared when a strictly greater score is found.
  - Registered into out_tie together with out_class and held through OUT.
- WISARD_TIE_FLAG_EN undefined: the out_tie port does not exist; all other behaviour is identical.

Test Plan:
- Full frame, 27 consecutive beats, s_sop on beat 0, hit_vec=10'h008 every beat -> out_valid after 11 cycles with out_class=3, out_score=27; ram_index sequence 0..26.
- Frame where class 2 hits 14 times and class 7 hits 14 times, all others 0 -> out_class=2, out_score=14; with WISARD_TIE_FLAG_EN, out_tie=1.
- s_valid toggled 1/0 every cycle over a frame with hit_vec=all ones -> every class scores 27, out_class=0; ram_index never skips or repeats.
- out_ready held low for 5 cycles in OUT -> out_valid, out_class and out_score stable, s_ready=0 throughout; frame 2 is accepted only after the handshake, and its scores start from 0.
- s_sop reasserted at beat 10 of a frame (class 5 hits on beats 0-9, class 1 hits afterwards) -> index restarts at 0; result class 1, score 27, class 5 score 0.
- rst_n low for 1 cycle at beat 15 or during SCAN -> out_valid=0, s_ready=1, ram_index=0 next cycle; a following clean frame classifies correctly.
